// File: rtl/regfile_onehot.sv
// 32-entry register file with one-hot decoded write enables, two combinational
// read ports, optional write-to-read bypass and optional hardwired-zero register 0.

module decoder (
  output logic [31:0] out,
  input  logic [4:0]  select,
  input  logic        enable
);

  // Comparison form keeps every output 0 when enable is low, even for an unknown select.
  always_comb begin
    out = '0;
    for (int i = 0; i < 32; i++) begin
      out[i] = enable && (select == 5'(i));
    end
  end

endmodule

module regfile_onehot #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          BYPASS     = 1'b1,
  parameter bit          ZERO_REG   = 1'b1
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  ctrl_writeEnable,
  input  logic [4:0]            ctrl_writeReg,
  input  logic [4:0]            ctrl_readRegA,
  input  logic [4:0]            ctrl_readRegB,
  input  logic [DATA_WIDTH-1:0] data_writeReg,
  output logic [DATA_WIDTH-1:0] data_readRegA,
  output logic [DATA_WIDTH-1:0] data_readRegB
);

  localparam int unsigned NUM_REGS = 32;

  logic [NUM_REGS-1:0]                 we;
  logic [NUM_REGS-1:0]                 we_eff;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;

  decoder u_decoder (
    .out    (we),
    .select (ctrl_writeReg),
    .enable (ctrl_writeEnable)
  );

  // Address 0 never writes and never bypasses when it is the zero register.
  assign we_eff = ZERO_REG ? (we & ~NUM_REGS'(1)) : we;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (ZERO_REG && (i == 0)) begin : g_zero
      assign regs[i] = '0;
    end else begin : g_store
      logic [DATA_WIDTH-1:0] q;

      always_ff @(posedge clock) begin
        if (ctrl_reset) begin
          q <= '0;
        end else if (we_eff[i]) begin
          q <= data_writeReg;
        end
      end

      assign regs[i] = q;
    end
  end

  // Read muxes; bypass is suppressed during reset since the write will be dropped.
  always_comb begin
    data_readRegA = regs[ctrl_readRegA];
    if (BYPASS && !ctrl_reset && we_eff[ctrl_readRegA]) begin
      data_readRegA = data_writeReg;
    end
  end

  always_comb begin
    data_readRegB = regs[ctrl_readRegB];
    if (BYPASS && !ctrl_reset && we_eff[ctrl_readRegB]) begin
      data_readRegB = data_writeReg;
    end
  end

endmodule

// File: tb/tb_regfile_onehot.sv
// Self-checking bench: a bypassing and a non-bypassing register file share stimulus
// and are compared every cycle against an array-based reference model.

module tb_regfile_onehot;

  localparam int unsigned DW = 32;

  logic          clock = 1'b0;
  logic          ctrl_reset;
  logic          ctrl_writeEnable;
  logic [4:0]    ctrl_writeReg;
  logic [4:0]    ctrl_readRegA;
  logic [4:0]    ctrl_readRegB;
  logic [DW-1:0] data_writeReg;
  logic [DW-1:0] byp_a, byp_b, nb_a, nb_b;

  logic [DW-1:0] mdl [32];
  int            n_vec = 0;
  int            n_err = 0;

  always #5 clock = ~clock;

  regfile_onehot #(.DATA_WIDTH(DW), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .data_writeReg    (data_writeReg),
    .data_readRegA    (byp_a),
    .data_readRegB    (byp_b)
  );

  regfile_onehot #(.DATA_WIDTH(DW), .BYPASS(1'b0), .ZERO_REG(1'b1)) dut_nb (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .data_writeReg    (data_writeReg),
    .data_readRegA    (nb_a),
    .data_readRegB    (nb_b)
  );

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] stored(input int a);
    return (a == 0) ? '0 : mdl[a];
  endfunction

  function automatic logic [DW-1:0] bypassed(input bit rst, input bit en, input int wr,
                                             input int rd, input logic [DW-1:0] wd);
    if (!rst && en && wr == rd && wr != 0) return wd;
    return stored(rd);
  endfunction

  // One clock cycle: drive inputs, check reads before the edge, then advance the model.
  task automatic step(input bit rst, input bit en, input int wr, input int ra, input int rb,
                      input logic [DW-1:0] wd, input bit chk);
    ctrl_reset       = rst;
    ctrl_writeEnable = en;
    ctrl_writeReg    = 5'(wr);
    ctrl_readRegA    = 5'(ra);
    ctrl_readRegB    = 5'(rb);
    data_writeReg    = wd;
    #2;
    if (chk) begin
      check_eq("byp_readA", byp_a, bypassed(rst, en, wr, ra, wd));
      check_eq("byp_readB", byp_b, bypassed(rst, en, wr, rb, wd));
      check_eq("nobyp_readA", nb_a, stored(ra));
      check_eq("nobyp_readB", nb_b, stored(rb));
    end
    @(posedge clock);
    if (rst) begin
      for (int i = 0; i < 32; i++) mdl[i] = '0;
    end else if (en && wr != 0) begin
      mdl[wr] = wd;
    end
    #1;
  endtask

  initial begin
    ctrl_reset = 1'b1; ctrl_writeEnable = 1'b0; ctrl_writeReg = '0;
    ctrl_readRegA = '0; ctrl_readRegB = '0; data_writeReg = '0;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    @(posedge clock); #1;

    // Registers are undefined before the first reset, so that cycle is not checked.
    step(1, 0, 0, 0, 0, '0, 0);
    for (int a = 0; a < 32; a++) step(0, 0, 0, a, 31 - a, '0, 1);

    step(0, 1, 5, 0, 0, 32'hDEADBEEF, 1);
    step(0, 0, 0, 5, 6, '0, 1);

    step(0, 1, 0, 0, 0, 32'h12345678, 1);
    step(0, 0, 0, 0, 0, '0, 1);

    step(0, 1, 31, 31, 31, 32'hA5A5A5A5, 1);
    step(0, 0, 0, 31, 31, '0, 1);

    for (int i = 1; i < 32; i++) step(0, 1, i, i, 0, DW'(i) * 32'h01010101, 1);
    for (int i = 1; i < 32; i++) step(0, 0, 0, i, 32 - i, '0, 1);
    step(0, 0, 7, 7, 7, 32'hFFFFFFFF, 1);
    step(0, 0, 0, 7, 7, '0, 1);

    step(1, 1, 9, 9, 9, 32'hCAFEF00D, 1);
    step(0, 0, 0, 9, 9, '0, 1);

    for (int i = 1; i < 32; i++) step(0, 1, i, 0, i, ~(DW'(i) * 32'h01010101), 1);
    step(1, 0, 0, 3, 4, '0, 1);
    for (int a = 0; a < 32; a++) step(0, 0, 0, a, a, '0, 1);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 2000; n++) begin
      automatic bit rst = ($urandom_range(0, 49) == 0);
      automatic bit en  = ($urandom_range(0, 3) != 0);
      automatic int wr  = $urandom_range(0, 31);
      automatic int ra  = ($urandom_range(0, 3) == 0) ? wr : $urandom_range(0, 31);
      automatic int rb  = ($urandom_range(0, 3) == 0) ? wr : $urandom_range(0, 31);
      step(rst, en, wr, ra, rb, DW'($urandom), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
